// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// memory geometry and the pipeline-to-memory address helper.
package dmem_arb_pkg;

   localparam int unsigned DMEM_AW = 12;
   localparam int unsigned DMEM_DW = 32;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LDR_ACC = 2'd1,
      LDR_RSP = 2'd2
   } arb_state_e;

   // The memory is 4 KiB, so only the low address bits reach the array.
   function automatic logic [DMEM_AW-1:0] to_mem_addr(input logic [31:0] addr);
      return addr[DMEM_AW-1:0];
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between pipeline memory stage, loader port and data memory.
// slave = arbiter view, master = environment view.
interface dmem_arbiter_if;
   import dmem_arb_pkg::*;

   logic               pipe_rd;
   logic               pipe_wr;
   logic [31:0]        pipe_addr;
   logic [31:0]        pipe_wdata;
   logic [DMEM_DW-1:0] pipe_rdata;
   logic               pipe_stall;

   logic               ldr_req;
   logic               ldr_we;
   logic [DMEM_AW-1:0] ldr_addr;
   logic [DMEM_DW-1:0] ldr_wdata;
   logic               ldr_ack;
   logic [DMEM_DW-1:0] ldr_rdata;

   logic [DMEM_AW-1:0] mem_addr;
   logic [DMEM_DW-1:0] mem_wdata;
   logic               mem_wr;
   logic               mem_rd;
   logic [DMEM_DW-1:0] mem_rdata;

   modport slave (
      input  pipe_rd, pipe_wr, pipe_addr, pipe_wdata,
      output pipe_rdata, pipe_stall,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_ack, ldr_rdata,
      output mem_addr, mem_wdata, mem_wr, mem_rd,
      input  mem_rdata
   );

   modport master (
      output pipe_rd, pipe_wr, pipe_addr, pipe_wdata,
      input  pipe_rdata, pipe_stall,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_ack, ldr_rdata,
      input  mem_addr, mem_wdata, mem_wr, mem_rd,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive blocked loader cycles and flags when the limit is reached
// so the arbiter can force a loader grant. Clear has priority over increment.
module dmem_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic limit_hit
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_r;

   // Blocked-cycle counter, saturating so it can never wrap back below the limit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign limit_hit = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the pipeline (priority, combinational
// pass-through) and the loader port. Optional starvation guard: DMEM_ARB_STARVE_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   arb_state_e         state_r;
   arb_state_e         state_nxt_s;

   logic               pipe_req_s;
   logic               grant_s;
   logic               force_s;

   logic [DMEM_AW-1:0] lat_addr_r;
   logic [DMEM_DW-1:0] lat_wdata_r;
   logic               lat_we_r;
   logic               ldr_ack_r;
   logic [DMEM_DW-1:0] ldr_rdata_r;

   logic [DMEM_AW-1:0] mem_addr_s;
   logic [DMEM_DW-1:0] mem_wdata_s;
   logic               mem_wr_s;
   logic               mem_rd_s;
   logic               pipe_stall_s;

   logic               pipe_addr_unused_s;

   assign pipe_addr_unused_s = ^bus.pipe_addr[31:DMEM_AW];

   assign pipe_req_s = bus.pipe_rd | bus.pipe_wr;
   assign grant_s    = (state_r == IDLE) && bus.ldr_req && (!pipe_req_s || force_s);

`ifdef DMEM_ARB_STARVE_EN
   logic ctr_clr_s;
   logic ctr_inc_s;

   assign ctr_clr_s = grant_s || !bus.ldr_req;
   assign ctr_inc_s = (state_r == IDLE) && bus.ldr_req && pipe_req_s;

   dmem_starve_ctr #(
      .LIMIT     (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr       (ctr_clr_s),
      .inc       (ctr_inc_s),
      .limit_hit (force_s)
   );
`else
   logic [CNT_W-1:0] starve_limit_unused_s;

   assign starve_limit_unused_s = CNT_W'(STARVE_LIMIT);
   assign force_s               = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: one access cycle and one response cycle per loader grant
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               state_nxt_s = LDR_ACC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LDR_ACC: state_nxt_s = LDR_RSP;
         LDR_RSP: state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Loader request capture on grant, so the loader may change fields after ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_addr_r  <= {DMEM_AW{1'b0}};
         lat_wdata_r <= {DMEM_DW{1'b0}};
         lat_we_r    <= 1'b0;
      end else if (grant_s) begin
         lat_addr_r  <= bus.ldr_addr;
         lat_wdata_r <= bus.ldr_wdata;
         lat_we_r    <= bus.ldr_we;
      end
   end

   // Loader response: ack follows the access cycle; read data captured at its end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ldr_ack_r   <= 1'b0;
         ldr_rdata_r <= {DMEM_DW{1'b0}};
      end else begin
         ldr_ack_r <= (state_r == LDR_ACC);
         if ((state_r == LDR_ACC) && !lat_we_r) begin
            ldr_rdata_r <= bus.mem_rdata;
         end
      end
   end

   // Memory port mux: pipeline mirrors through except during the loader access cycle
   always_comb begin
      mem_addr_s   = to_mem_addr(bus.pipe_addr);
      mem_wdata_s  = bus.pipe_wdata;
      mem_wr_s     = bus.pipe_wr;
      mem_rd_s     = bus.pipe_rd;
      pipe_stall_s = 1'b0;
      if (state_r == LDR_ACC) begin
         mem_addr_s   = lat_addr_r;
         mem_wdata_s  = lat_wdata_r;
         mem_wr_s     = lat_we_r;
         mem_rd_s     = !lat_we_r;
         pipe_stall_s = pipe_req_s;
      end else begin
         pipe_stall_s = 1'b0;
      end
   end

   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_wdata  = mem_wdata_s;
   assign bus.mem_wr     = mem_wr_s;
   assign bus.mem_rd     = mem_rd_s;
   assign bus.pipe_stall = pipe_stall_s;
   assign bus.pipe_rdata = bus.mem_rdata;
   assign bus.ldr_ack    = ldr_ack_r;
   assign bus.ldr_rdata  = ldr_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a timing/shadow-memory reference model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned LIMIT = 8;

   logic clk = 1'b0;
   logic rst;
   logic clr_mem;

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter #(
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Data memory model: combinational read, write on the clock edge
   logic [31:0] mem [0:1023];
   assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= (i == 64) ? 32'h1234_5678 : 32'h0;
      end else if (bus.mem_wr) begin
         mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int          cyc       = 0;
   int          grant_cyc = -10;
   int          blocked   = 0;
   logic [31:0] shadow [0:1023];
   logic [11:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_we;
   logic [31:0] m_rdata;
   logic        last_ack;
   logic        exp_stall_q;
   logic [31:0] rnd;
   int          n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_pipe(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
      bus.pipe_rd    = rd;
      bus.pipe_wr    = wr;
      bus.pipe_addr  = addr;
      bus.pipe_wdata = wdata;
   endtask

   task automatic set_ldr(input logic we, input logic [11:0] addr, input logic [31:0] wdata);
      bus.ldr_req   = 1'b1;
      bus.ldr_we    = we;
      bus.ldr_addr  = addr;
      bus.ldr_wdata = wdata;
   endtask

   // One clock cycle: predict, compare on the falling edge, then advance the model
   task automatic step();
      int          since;
      logic        in_acc, in_rsp, idle, pipe_req, starved;
      logic [11:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_wr, e_rd, e_stall;
      since    = cyc - grant_cyc;
      in_acc   = (since == 1);
      in_rsp   = (since == 2);
      idle     = !in_acc && !in_rsp;
      pipe_req = bus.pipe_rd | bus.pipe_wr;
      e_addr   = in_acc ? m_addr  : bus.pipe_addr[11:0];
      e_wdata  = in_acc ? m_wdata : bus.pipe_wdata;
      e_wr     = in_acc ? m_we    : bus.pipe_wr;
      e_rd     = in_acc ? !m_we   : bus.pipe_rd;
      e_stall  = in_acc && pipe_req;
`ifdef DMEM_ARB_STARVE_EN
      starved  = (blocked == int'(LIMIT));
`else
      starved  = 1'b0;
`endif
      @(negedge clk);
      check("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
      check("mem_wdata",  bus.mem_wdata,       e_wdata);
      check("mem_wr",     32'(bus.mem_wr),     32'(e_wr));
      check("mem_rd",     32'(bus.mem_rd),     32'(e_rd));
      check("pipe_stall", 32'(bus.pipe_stall), 32'(e_stall));
      check("ldr_ack",    32'(bus.ldr_ack),    32'(in_rsp));
      check("ldr_rdata",  bus.ldr_rdata,       m_rdata);
      if (e_rd) check("pipe_rdata", bus.pipe_rdata, shadow[e_addr[11:2]]);
      last_ack    = bus.ldr_ack;
      exp_stall_q = e_stall;
      if (in_acc && !m_we) m_rdata = shadow[m_addr[11:2]];
      if (idle && bus.ldr_req && (!pipe_req || starved)) begin
         grant_cyc = cyc;
         m_addr    = bus.ldr_addr;
         m_wdata   = bus.ldr_wdata;
         m_we      = bus.ldr_we;
      end
      if ((grant_cyc == cyc) || !bus.ldr_req) blocked = 0;
      else if (idle && pipe_req) blocked++;
      if (e_wr) shadow[e_addr[11:2]] = e_wdata;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_ack(input string tag, input int budget, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!last_ack && cnt < budget);
      check({tag, "_ack_seen"}, 32'(last_ack), 32'd1);
      bus.ldr_req = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      bus.ldr_req = 1'b0;
      set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("rst_ldr_ack",   32'(bus.ldr_ack), 32'd0);
      check("rst_ldr_rdata", bus.ldr_rdata,    32'd0);
      check("rst_mem_wr",    32'(bus.mem_wr),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      grant_cyc   = cyc - 10;
      blocked     = 0;
      m_rdata     = 32'h0;
      last_ack    = 1'b0;
      exp_stall_q = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = (i == 64) ? 32'h1234_5678 : 32'h0;
      m_addr = 12'h0; m_wdata = 32'h0; m_we = 1'b0; m_rdata = 32'h0;
      bus.ldr_we = 1'b0; bus.ldr_addr = 12'h0; bus.ldr_wdata = 32'h0;
      clr_mem = 1'b1;
      do_reset();
      clr_mem = 1'b0;

      // Idle loader write, then pipeline load of the same word
      set_ldr(1'b1, 12'h010, 32'hDEAD_BEEF);
      wait_ack("ldr_wr", 6, n);
      check("ldr_wr_latency", 32'(n), 32'd3);
      set_pipe(1'b1, 1'b0, 32'hABCD_E010, 32'h0);
      step();
      check("pipe_ld_010", bus.pipe_rdata, 32'hDEAD_BEEF);
      set_pipe(1'b0, 1'b0, 32'h0, 32'h0);

      // Loader read of a preloaded word
      set_ldr(1'b0, 12'h100, 32'h0);
      wait_ack("ldr_rd", 6, n);
      check("ldr_rd_latency", 32'(n), 32'd3);
      check("ldr_rd_data", bus.ldr_rdata, 32'h1234_5678);

      // Pipeline priority: five busy cycles, then the loader gets the first idle one
      set_pipe(1'b1, 1'b0, 32'h0000_0200, 32'h0);
      set_ldr(1'b0, 12'h010, 32'h0);
      for (int i = 0; i < 5; i++) step();
      set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
      wait_ack("prio", 6, n);
      check("prio_latency", 32'(n), 32'd3);
      check("prio_rdata", bus.ldr_rdata, 32'hDEAD_BEEF);

      // Starvation: pipeline never idle
      bus.ldr_req = 1'b0;
      step();
      set_pipe(1'b1, 1'b0, 32'h0000_0100, 32'h0);
      set_ldr(1'b0, 12'h010, 32'h0);
      n = 0;
      do begin
         step();
         n++;
      end while (!last_ack && n < 50);
`ifdef DMEM_ARB_STARVE_EN
      check("starve_latency", 32'(n), 32'(LIMIT + 3));
      bus.ldr_req = 1'b0;
      set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
`else
      check("starve_no_ack", 32'(last_ack), 32'd0);
      set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
      wait_ack("starve_release", 6, n);
      check("starve_release_latency", 32'(n), 32'd3);
`endif

      // Reset while the loader access is in flight
      set_ldr(1'b0, 12'h100, 32'h0);
      step();
      do_reset();
      for (int i = 0; i < 4; i++) step();
      set_ldr(1'b0, 12'h100, 32'h0);
      wait_ack("reissue", 6, n);
      check("reissue_rdata", bus.ldr_rdata, 32'h1234_5678);

      // Randomized mixed traffic
      for (int i = 0; i < 2000; i++) begin
         if (last_ack) begin
            bus.ldr_req = 1'b0;
         end else if (!bus.ldr_req && ($urandom_range(0, 3) == 0)) begin
            rnd = $urandom;
            set_ldr(rnd[0], 12'($urandom_range(0, 31) * 4), $urandom);
         end
         if (!exp_stall_q) begin
            rnd = $urandom;
            case ($urandom_range(0, 9))
               0, 1, 2: set_pipe(1'b1, 1'b0, {rnd[31:12], 12'($urandom_range(0, 31) * 4)}, 32'h0);
               3, 4, 5: set_pipe(1'b0, 1'b1, {rnd[31:12], 12'($urandom_range(0, 31) * 4)}, $urandom);
               default: set_pipe(1'b0, 1'b0, rnd, 32'h0);
            endcase
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
